argmax_classifier: RTL and testbench

Sequential argmax/decision stage directly downstream of the softmax unit in the inference pipeline. It captures the 10-class Q8.8 probability vector on the softmax `out_valid` pulse and scans it one class per cycle for the winning class, its confidence and the margin over the runner-up. Each decision is pushed into a small first-word-fall-through result FIFO, which is drained by the host/display logic through a valid/ready handshake.

---
 rtl/argmax_classifier.sv | 212 +++++++++++++++++++++
 tb/tb_argmax_classifier.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// argmax_classifier: sequential argmax/decision stage behind the softmax unit.
// A captured 10-class Q8.8 probability vector is scanned one class per cycle
// to find the winner, its confidence and the margin over the runner-up. Each
// decision goes into a small first-word-fall-through FIFO drained by the host
// through a valid/ready handshake.
module argmax_classifier #(
    parameter int                 NUM_CLASSES = 10,
    parameter int                 DATA_W      = 16,
    parameter logic [DATA_W-1:0]  CONF_THRESH = 16'h0080,
    parameter int                 FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLASSES*DATA_W-1:0] probs,
    input  logic                          in_valid,
    output logic                          busy,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [3:0]                    class_id,
    output logic [DATA_W-1:0]             confidence,
    output logic [DATA_W-1:0]             margin,
    output logic                          low_conf,
    output logic [7:0]                    drop_count,
    output logic                          overflow
);

    localparam int IDX_W = 4;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    // Scan datapath state
    state_t              state_r;
    logic [DATA_W-1:0]   cap_r [NUM_CLASSES];
    logic [IDX_W-1:0]    count_r;
    logic [DATA_W-1:0]   best_r;
    logic [DATA_W-1:0]   second_r;
    logic [IDX_W-1:0]    best_idx_r;

    // Result FIFO storage and bookkeeping
    logic [IDX_W-1:0]    fifo_idx_r    [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_conf_r   [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_margin_r [FIFO_DEPTH];
    logic                fifo_low_r    [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W:0]      occ_r;

    logic [7:0]          drop_count_r;
    logic                overflow_r;

    // Combinational helpers
    logic [DATA_W-1:0]   cur_p_s;
    logic                full_s;
    logic                not_empty_s;
    logic                pop_s;
    logic                push_req_s;
    logic                push_s;
    logic                drop_push_s;
    logic                drop_busy_s;
    logic [8:0]          drop_sum_s;
    logic [7:0]          drop_next_s;
    logic [DATA_W-1:0]   entry_margin_s;
    logic                entry_low_s;

    // Saturating 8-bit add used by the lost-frame counter
    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [8:0] sum);
        logic [7:0] res;
        if (sum > 9'd255) begin
            res = 8'hFF;
        end else begin
            res = sum[7:0];
        end
        return (base == 8'hFF) ? 8'hFF : res;
    endfunction

    // Current class value, FIFO status and push/pop/drop decisions
    always_comb begin
        cur_p_s        = cap_r[count_r];
        full_s         = (occ_r == (PTR_W+1)'(FIFO_DEPTH));
        not_empty_s    = (occ_r != {(PTR_W+1){1'b0}});
        pop_s          = not_empty_s && res_ready;
        push_req_s     = (state_r == ST_PUSH);
        push_s         = push_req_s && (!full_s || pop_s);
        drop_push_s    = push_req_s && !push_s;
        drop_busy_s    = in_valid && (state_r != ST_IDLE);
        drop_sum_s     = {1'b0, drop_count_r} + {8'd0, drop_push_s} + {8'd0, drop_busy_s};
        drop_next_s    = sat_add8(drop_count_r, drop_sum_s);
        entry_margin_s = best_r - second_r;
        entry_low_s    = (best_r < CONF_THRESH);
    end

    // Frame FSM: capture on accept, scan one class per cycle, then push
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            count_r    <= {IDX_W{1'b0}};
            best_r     <= {DATA_W{1'b0}};
            second_r   <= {DATA_W{1'b0}};
            best_idx_r <= {IDX_W{1'b0}};
            for (int i = 0; i < NUM_CLASSES; i++) begin
                cap_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            cap_r[i] <= probs[i*DATA_W +: DATA_W];
                        end
                        count_r    <= {IDX_W{1'b0}};
                        best_r     <= {DATA_W{1'b0}};
                        second_r   <= {DATA_W{1'b0}};
                        best_idx_r <= {IDX_W{1'b0}};
                        state_r    <= ST_SCAN;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    // Strict compare keeps ties on the lowest index; an equal
                    // runner-up still lands in second, giving a zero margin.
                    if (cur_p_s > best_r) begin
                        second_r   <= best_r;
                        best_r     <= cur_p_s;
                        best_idx_r <= count_r;
                    end else if (cur_p_s > second_r) begin
                        second_r   <= cur_p_s;
                    end else begin
                        second_r   <= second_r;
                    end
                    count_r <= count_r + 4'd1;
                    if (count_r == IDX_W'(NUM_CLASSES - 1)) begin
                        state_r <= ST_PUSH;
                    end else begin
                        state_r <= ST_SCAN;
                    end
                end
                ST_PUSH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Result FIFO: write on push, advance read pointer on pop, track occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                fifo_idx_r[wr_ptr_r]    <= best_idx_r;
                fifo_conf_r[wr_ptr_r]   <= best_r;
                fifo_margin_r[wr_ptr_r] <= entry_margin_s;
                fifo_low_r[wr_ptr_r]    <= entry_low_s;
                wr_ptr_r                <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 1'b1;
                2'b01:   occ_r <= occ_r - 1'b1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Lost-frame counter and sticky FIFO overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_r <= 8'd0;
            overflow_r   <= 1'b0;
        end else begin
            drop_count_r <= drop_next_s;
            overflow_r   <= overflow_r | drop_push_s;
        end
    end

    // FIFO head view; fields read as zero whenever nothing is queued
    always_comb begin
        busy       = (state_r != ST_IDLE);
        res_valid  = not_empty_s;
        drop_count = drop_count_r;
        overflow   = overflow_r;
        if (not_empty_s) begin
            class_id   = fifo_idx_r[rd_ptr_r];
            confidence = fifo_conf_r[rd_ptr_r];
            margin     = fifo_margin_r[rd_ptr_r];
            low_conf   = fifo_low_r[rd_ptr_r];
        end else begin
            class_id   = 4'd0;
            confidence = {DATA_W{1'b0}};
            margin     = {DATA_W{1'b0}};
            low_conf   = 1'b0;
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed self-checking bench for argmax_classifier.
module tb_argmax_classifier;

    logic         clk;
    logic         rst;
    logic [159:0] probs;
    logic         in_valid;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [3:0]   class_id;
    logic [15:0]  confidence;
    logic [15:0]  margin;
    logic         low_conf;
    logic [7:0]   drop_count;
    logic         overflow;

    int n_cmp;
    int n_err;

    argmax_classifier dut (
        .clk        (clk),
        .rst        (rst),
        .probs      (probs),
        .in_valid   (in_valid),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .class_id   (class_id),
        .confidence (confidence),
        .margin     (margin),
        .low_conf   (low_conf),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector with every class at 'lo' except class 'k' at 'hi'
    function automatic logic [159:0] mk_vec(input int k, input logic [15:0] hi, input logic [15:0] lo);
        logic [159:0] v;
        for (int i = 0; i < 10; i++) v[i*16 +: 16] = lo;
        v[k*16 +: 16] = hi;
        return v;
    endfunction

    // Reset for two edges; returns at a falling edge with rst low
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a falling edge: pulse in_valid across one rising edge (E0)
    task automatic send_frame(input logic [159:0] v);
        probs = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        n_cmp++; if ({class_id, confidence, margin, low_conf} !== 37'd0) begin n_err++;
            $display("FAIL reset_head: got %h/%h/%h/%b want zeros", class_id, confidence, margin, low_conf); end
        n_cmp++; if ({drop_count, overflow} !== 9'd0) begin n_err++;
            $display("FAIL reset_drop: got %0d/%b want 0/0", drop_count, overflow); end
    endtask

    task automatic test_one_hot();
        do_reset();
        res_ready = 1'b1;
        send_frame(mk_vec(7, 16'h0100, 16'h0000));
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL onehot_busy: got %b want 1", busy); end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL onehot_early_valid at E%0d: got %b want 0", k, res_valid); end
        end
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL onehot_valid: got %b want 1", res_valid); end
        n_cmp++; if (class_id !== 4'd7) begin n_err++; $display("FAIL onehot_class: got %0d want 7", class_id); end
        n_cmp++; if (confidence !== 16'h0100) begin n_err++; $display("FAIL onehot_conf: got %h want 0100", confidence); end
        n_cmp++; if (margin !== 16'h0100) begin n_err++; $display("FAIL onehot_margin: got %h want 0100", margin); end
        n_cmp++; if (low_conf !== 1'b0) begin n_err++; $display("FAIL onehot_low: got %b want 0", low_conf); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL onehot_idle: got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL onehot_pulse: got %b want 0", res_valid); end
        n_cmp++; if (confidence !== 16'h0000) begin n_err++; $display("FAIL onehot_zero_head: got %h want 0000", confidence); end
        res_ready = 1'b0;
    endtask

    task automatic test_tie_threshold();
        logic [159:0] v;
        do_reset();
        v = mk_vec(2, 16'h0060, 16'h0010);
        v[5*16 +: 16] = 16'h0060;
        send_frame(v);
        repeat (11) @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL tie_valid: got %b want 1", res_valid); end
        n_cmp++; if (class_id !== 4'd2) begin n_err++; $display("FAIL tie_class: got %0d want 2", class_id); end
        n_cmp++; if (confidence !== 16'h0060) begin n_err++; $display("FAIL tie_conf: got %h want 0060", confidence); end
        n_cmp++; if (margin !== 16'h0000) begin n_err++; $display("FAIL tie_margin: got %h want 0000", margin); end
        n_cmp++; if (low_conf !== 1'b1) begin n_err++; $display("FAIL tie_low: got %b want 1", low_conf); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int f = 0; f < 5; f++) begin
            send_frame(mk_vec(f, 16'h0200, 16'h0010));
            repeat (11) @(negedge clk);
        end
        n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL bp_drop: got %0d want 1", drop_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow: got %b want 1", overflow); end
        n_cmp++; if (margin !== 16'h01F0) begin n_err++; $display("FAIL bp_margin: got %h want 01f0", margin); end
        // Head must hold steady under backpressure
        @(negedge clk);
        n_cmp++; if (class_id !== 4'd0) begin n_err++; $display("FAIL bp_stable: got %0d want 0", class_id); end
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (res_valid !== 1'b1 || class_id !== 4'(k)) begin n_err++;
                $display("FAIL bp_order[%0d]: got valid=%b id=%0d want valid=1 id=%0d", k, res_valid, class_id, k); end
            @(negedge clk);
        end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", res_valid); end
        res_ready = 1'b0;
    endtask

    task automatic test_busy_drop();
        do_reset();
        send_frame(mk_vec(3, 16'h0200, 16'h0000));
        repeat (4) @(negedge clk);
        send_frame(mk_vec(8, 16'h0300, 16'h0000));
        repeat (6) @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1 || class_id !== 4'd3) begin n_err++;
            $display("FAIL busy_class: got valid=%b id=%0d want valid=1 id=3", res_valid, class_id); end
        n_cmp++; if (confidence !== 16'h0200 || margin !== 16'h0200) begin n_err++;
            $display("FAIL busy_fields: got %h/%h want 0200/0200", confidence, margin); end
        n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL busy_drop: got %0d want 1", drop_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL busy_overflow: got %b want 0", overflow); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL busy_single: got %b want 0", res_valid); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int f = 5; f < 9; f++) begin
            send_frame(mk_vec(f, 16'h0200, 16'h0010));
            repeat (11) @(negedge clk);
        end
        send_frame(mk_vec(9, 16'h0200, 16'h0010));
        repeat (10) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++; if (drop_count !== 8'd0 || overflow !== 1'b0) begin n_err++;
            $display("FAIL fullpop_drop: got %0d/%b want 0/0", drop_count, overflow); end
        res_ready = 1'b1;
        for (int k = 6; k < 10; k++) begin
            n_cmp++; if (res_valid !== 1'b1 || class_id !== 4'(k)) begin n_err++;
                $display("FAIL fullpop_order[%0d]: got valid=%b id=%0d want valid=1", k, res_valid, class_id); end
            @(negedge clk);
        end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_empty: got %b want 0", res_valid); end
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        send_frame(mk_vec(1, 16'h0200, 16'h0000));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({busy, res_valid, drop_count, overflow} !== 11'd0) begin n_err++;
            $display("FAIL midrst_outputs: got busy=%b valid=%b drop=%0d ovf=%b want zeros", busy, res_valid, drop_count, overflow); end
        repeat (8) @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_result: got %b want 0", res_valid); end
        send_frame(mk_vec(4, 16'h0200, 16'h0000));
        repeat (10) @(negedge clk);
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL midrst_early: got %b want 0", res_valid); end
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1 || class_id !== 4'd4) begin n_err++;
            $display("FAIL midrst_next: got valid=%b id=%0d want valid=1 id=4", res_valid, class_id); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        probs = 160'd0;
        test_reset();
        test_one_hot();
        test_tie_threshold();
        test_backpressure();
        test_busy_drop();
        test_full_pop();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
